// File: rtl/mcp_arb.sv
// mcp_arb: round-robin arbiter and sequencer in front of a single mcp send
// port. One requester at a time is granted and its word is launched with a
// single-cycle asend. The arbiter then waits for the mcp handshake to return
// aready and acknowledges the winner with a one-cycle ack pulse. A watchdog
// flags a transfer whose handshake never comes back.

module mcp_arb #(
  parameter int DWIDTH  = 8,
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 255
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DWIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]        ack,
  output logic [NUM_REQ-1:0]        grant,
  output logic                      busy,
  output logic                      asend,
  output logic [DWIDTH-1:0]         adatain,
  input  logic                      aready,
  output logic                      timeout_err,
  input  logic                      err_clr
);

  // Index width for a requester number, watchdog width able to hold TIMEOUT.
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int WW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // Registered state and outputs.
  state_t              state_reg,    state_next;
  logic [NUM_REQ-1:0]  grant_reg,    grant_next;
  logic [NUM_REQ-1:0]  ack_reg,      ack_next;
  logic                asend_reg,    asend_next;
  logic                busy_reg,     busy_next;
  logic [DWIDTH-1:0]   adatain_reg,  adatain_next;
  logic                err_reg,      err_next;
  logic [IW-1:0]       last_reg,     last_next;
  logic [IW-1:0]       win_idx_reg,  win_idx_next;
  logic [WW-1:0]       wd_reg,       wd_next;
  logic                seen_low_reg, seen_low_next;

  // Arbitration results for the current cycle.
  logic [DWIDTH-1:0]   req_word [NUM_REQ];
  logic                pick_found;
  logic [IW-1:0]       pick_idx;
  logic [NUM_REQ-1:0]  pick_onehot;
  logic                err_set;
  int                  scan_idx;
  logic [IW-1:0]       cand_idx;

  // Split the flattened request bus into per-requester words and build the
  // one-hot form of the winning index.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
    assign req_word[gi]    = req_data[gi*DWIDTH +: DWIDTH];
    assign pick_onehot[gi] = (pick_idx == IW'(gi));
  end

  // Round-robin pick: scan from last+1 upward with wrap. The loop runs from
  // the farthest candidate down to the nearest, so the nearest set request
  // is the final assignment and wins.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    scan_idx   = 0;
    cand_idx   = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      scan_idx = (int'(last_reg) + k) % NUM_REQ;
      cand_idx = IW'(scan_idx);
      if (req[cand_idx]) begin
        pick_found = 1'b1;
        pick_idx   = cand_idx;
      end
    end
  end

  // Sequencer next-state and output logic: IDLE -> SEND -> WAIT -> DONE.
  always_comb begin
    state_next    = state_reg;
    grant_next    = grant_reg;
    ack_next      = '0;
    asend_next    = 1'b0;
    adatain_next  = adatain_reg;
    last_next     = last_reg;
    win_idx_next  = win_idx_reg;
    wd_next       = wd_reg;
    seen_low_next = seen_low_reg;
    err_set       = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        // Only launch while the mcp can take a word; otherwise issue nothing.
        if (pick_found && aready) begin
          state_next   = ST_SEND;
          grant_next   = pick_onehot;
          win_idx_next = pick_idx;
          adatain_next = req_word[pick_idx];
          asend_next   = 1'b1;
        end
      end

      ST_SEND: begin
        // The mcp captures adatain this cycle; start a fresh handshake watch.
        state_next    = ST_WAIT;
        wd_next       = '0;
        seen_low_next = 1'b0;
      end

      ST_WAIT: begin
        // Saturating watchdog; the flag fires once on the step into TIMEOUT.
        if (wd_reg != WW'(TIMEOUT)) begin
          wd_next = wd_reg + 1'b1;
        end
        if (wd_reg == WW'(TIMEOUT - 1)) begin
          err_set = 1'b1;
        end
        // A high aready only counts once the mcp has been seen busy, so a
        // stale ready from before the launch cannot complete the transfer.
        if (!aready) begin
          seen_low_next = 1'b1;
        end
        if (seen_low_reg && aready) begin
          state_next = ST_DONE;
          ack_next   = grant_reg;
          last_next  = win_idx_reg;
        end
      end

      ST_DONE: begin
        state_next = ST_IDLE;
        grant_next = '0;
      end

      default: begin
        state_next = ST_IDLE;
        grant_next = '0;
      end
    endcase

    busy_next = (state_next != ST_IDLE);

    // Sticky error: a new timeout takes priority over a coincident clear.
    if (err_set) begin
      err_next = 1'b1;
    end else if (err_clr) begin
      err_next = 1'b0;
    end else begin
      err_next = err_reg;
    end
  end

  // State and output registers; reset abandons any in-flight transfer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= ST_IDLE;
      grant_reg    <= '0;
      ack_reg      <= '0;
      asend_reg    <= 1'b0;
      busy_reg     <= 1'b0;
      adatain_reg  <= '0;
      err_reg      <= 1'b0;
      last_reg     <= IW'(NUM_REQ - 1);
      win_idx_reg  <= '0;
      wd_reg       <= '0;
      seen_low_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      grant_reg    <= grant_next;
      ack_reg      <= ack_next;
      asend_reg    <= asend_next;
      busy_reg     <= busy_next;
      adatain_reg  <= adatain_next;
      err_reg      <= err_next;
      last_reg     <= last_next;
      win_idx_reg  <= win_idx_next;
      wd_reg       <= wd_next;
      seen_low_reg <= seen_low_next;
    end
  end

  assign ack         = ack_reg;
  assign grant       = grant_reg;
  assign busy        = busy_reg;
  assign asend       = asend_reg;
  assign adatain     = adatain_reg;
  assign timeout_err = err_reg;

endmodule
